// File: rtl/gb80_mem_controller_pkg.sv
// Shared definitions for the gb80 memory controller: region tags,
// address-map boundaries, FSM states and access classes.
package gb80_mem_controller_pkg;

  localparam logic [2:0] REG_ROM    = 3'd0;
  localparam logic [2:0] REG_VRAM   = 3'd1;
  localparam logic [2:0] REG_EXTRAM = 3'd2;
  localparam logic [2:0] REG_WRAM   = 3'd3;
  localparam logic [2:0] REG_OAM    = 3'd4;
  localparam logic [2:0] REG_IO     = 3'd5;

  localparam logic [15:0] A_VRAM   = 16'h8000;
  localparam logic [15:0] A_EXTRAM = 16'hA000;
  localparam logic [15:0] A_WRAM   = 16'hC000;
  localparam logic [15:0] A_ECHO   = 16'hE000;
  localparam logic [15:0] A_OAM    = 16'hFE00;
  localparam logic [15:0] A_UNUSE  = 16'hFEA0;
  localparam logic [15:0] A_IO     = 16'hFF00;
  localparam logic [15:0] A_HRAM   = 16'hFF80;
  localparam logic [15:0] A_IE     = 16'hFFFF;
  localparam logic [15:0] ECHO_OFS = 16'h2000;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EXT,
    ST_DONE
  } state_t;

  typedef enum logic [1:0] {
    K_EXT,
    K_HRAM,
    K_IE,
    K_NONE
  } kind_t;

endpackage

// File: rtl/gb80_mem_controller_hram.sv
// High RAM (FF80-FFFE): 127x8, synchronous write, registered read.
// Ports: clk, we/re enables, 7-bit index, wdata in, rdata out.
module gb80_mem_controller_hram (
  input  logic       clk,
  input  logic       we,
  input  logic       re,
  input  logic [6:0] idx,
  input  logic [7:0] wdata,
  output logic [7:0] rdata
);

  logic [7:0] mem [0:126];

  // Index 7F maps to IE, never to this array.
  always_ff @(posedge clk) begin
    if (we && idx != 7'h7F)
      mem[idx] <= wdata;
    if (re)
      rdata <= (idx == 7'h7F) ? 8'h00 : mem[idx];
  end

endmodule

// File: rtl/gb80_mem_controller.sv
// CPU-to-memory-map bus controller: decodes the 16-bit map, runs the
// external bus with WAIT_CYCLES wait states, serves HRAM and IE
// internally. Ports: i_cpu_* request side, o_cpu_ready/done/rdata,
// o_mem_* external bus with region tag, i_mem_rdata, o_ie.
// Build option: GB80_ECHO_RAM_EN maps E000-FDFF onto WRAM.
module gb80_mem_controller
  import gb80_mem_controller_pkg::*;
#(
  parameter int         WAIT_CYCLES   = 1,
  parameter logic [7:0] UNMAPPED_DATA = 8'hFF
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_cpu_req,
  input  logic        i_cpu_we,
  input  logic [15:0] i_cpu_addr,
  input  logic [7:0]  i_cpu_wdata,
  output logic        o_cpu_ready,
  output logic        o_cpu_done,
  output logic [7:0]  o_cpu_rdata,
  output logic [15:0] o_mem_addr,
  output logic [7:0]  o_mem_wdata,
  output logic        o_mem_re,
  output logic        o_mem_we,
  output logic [2:0]  o_mem_region,
  input  logic [7:0]  i_mem_rdata,
  output logic [7:0]  o_ie
);

  state_t      state, state_n;
  kind_t       dec_kind, kind_q;
  logic [2:0]  dec_region;
  logic [15:0] dec_addr;
  logic [3:0]  cnt;
  logic        we_q;
  logic [7:0]  rdata_q;
  logic [7:0]  hram_rdata;
  logic        accept;
  logic        hram_rd_done;

  always_comb begin
    dec_kind   = K_NONE;
    dec_region = REG_ROM;
    dec_addr   = i_cpu_addr;
    if (i_cpu_addr < A_VRAM) begin
      dec_kind = K_EXT;
    end else if (i_cpu_addr < A_EXTRAM) begin
      dec_kind   = K_EXT;
      dec_region = REG_VRAM;
    end else if (i_cpu_addr < A_WRAM) begin
      dec_kind   = K_EXT;
      dec_region = REG_EXTRAM;
    end else if (i_cpu_addr < A_ECHO) begin
      dec_kind   = K_EXT;
      dec_region = REG_WRAM;
    end else if (i_cpu_addr < A_OAM) begin
`ifdef GB80_ECHO_RAM_EN
      dec_kind   = K_EXT;
      dec_region = REG_WRAM;
      dec_addr   = i_cpu_addr - ECHO_OFS;
`else
      dec_kind   = K_NONE;
`endif
    end else if (i_cpu_addr < A_UNUSE) begin
      dec_kind   = K_EXT;
      dec_region = REG_OAM;
    end else if (i_cpu_addr < A_IO) begin
      dec_kind = K_NONE;
    end else if (i_cpu_addr < A_HRAM) begin
      dec_kind   = K_EXT;
      dec_region = REG_IO;
    end else if (i_cpu_addr < A_IE) begin
      dec_kind = K_HRAM;
    end else begin
      dec_kind = K_IE;
    end
  end

  assign accept = i_cpu_req && (state == ST_IDLE);

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) state <= ST_IDLE;
    else         state <= state_n;
  end

  always_comb begin
    state_n     = state;
    o_cpu_ready = 1'b0;
    o_cpu_done  = 1'b0;
    o_mem_re    = 1'b0;
    o_mem_we    = 1'b0;
    unique case (state)
      ST_IDLE: begin
        o_cpu_ready = 1'b1;
        if (i_cpu_req)
          state_n = (dec_kind == K_EXT) ? ST_EXT : ST_DONE;
      end
      ST_EXT: begin
        o_mem_re = !we_q;
        o_mem_we = we_q;
        if (cnt == 4'd0) state_n = ST_DONE;
      end
      ST_DONE: begin
        o_cpu_done = 1'b1;
        state_n    = ST_IDLE;
      end
      default: state_n = ST_IDLE;
    endcase
  end

  assign hram_rd_done = (state == ST_DONE) && (kind_q == K_HRAM) && !we_q;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      o_mem_addr   <= 16'h0000;
      o_mem_wdata  <= 8'h00;
      o_mem_region <= 3'd0;
      we_q         <= 1'b0;
      kind_q       <= K_NONE;
      cnt          <= 4'd0;
      rdata_q      <= 8'h00;
      o_ie         <= 8'h00;
    end else begin
      if (accept) begin
        o_mem_addr   <= dec_addr;
        o_mem_wdata  <= i_cpu_wdata;
        o_mem_region <= dec_region;
        we_q         <= i_cpu_we;
        kind_q       <= dec_kind;
        cnt          <= 4'(WAIT_CYCLES);
        if (i_cpu_we && dec_kind == K_IE)
          o_ie <= i_cpu_wdata;
        if (!i_cpu_we && dec_kind == K_IE)
          rdata_q <= o_ie;
        if (!i_cpu_we && dec_kind == K_NONE)
          rdata_q <= UNMAPPED_DATA;
      end
      if (state == ST_EXT) begin
        if (cnt == 4'd0) begin
          if (!we_q) rdata_q <= i_mem_rdata;
        end else begin
          cnt <= cnt - 4'd1;
        end
      end
      if (hram_rd_done)
        rdata_q <= hram_rdata;
    end
  end

  // HRAM read data arrives one edge after accept; show it directly in DONE.
  assign o_cpu_rdata = hram_rd_done ? hram_rdata : rdata_q;

  gb80_mem_controller_hram u_hram (
    .clk   (i_clk),
    .we    (accept && dec_kind == K_HRAM && i_cpu_we),
    .re    (accept && dec_kind == K_HRAM && !i_cpu_we),
    .idx   (i_cpu_addr[6:0]),
    .wdata (i_cpu_wdata),
    .rdata (hram_rdata)
  );

endmodule

// File: doc/gb80_mem_controller.md
Name: gb80_mem_controller

Overview:
- Memory bus controller between gb80_processor and the system memory map.
- Accepts single-byte read/write requests from the CPU, decodes the 16-bit Game Boy address map and drives a region-tagged external bus with programmable wait states.
- Services HRAM (FF80–FFFE) and the IE register (FFFF) internally.
- Returns read data to the CPU data bus with a one-cycle done pulse.

Parameters:
- WAIT_CYCLES, 1, extra external-bus cycles per access; legal range 0–15.
- UNMAPPED_DATA, 8'hFF, read value for unmapped or unusable addresses.

Ports:
- i_clk  in  1  system clock
- i_reset  in  1  asynchronous active-high reset
- i_cpu_req  in  1  CPU access request; qualified by o_cpu_ready
- i_cpu_we  in  1  1 = write, 0 = read
- i_cpu_addr  in  16  byte address
- i_cpu_wdata  in  8  write data
- o_cpu_ready  out  1  controller idle, can accept a request
- o_cpu_done  out  1  one-cycle pulse: access complete
- o_cpu_rdata  out  8  read data; valid when o_cpu_done and the access was a read
- o_mem_addr  out  16  external address
- o_mem_wdata  out  8  external write data
- o_mem_re  out  1  external read strobe
- o_mem_we  out  1  external write strobe
- o_mem_region  out  3  region tag: 0 ROM, 1 VRAM, 2 EXTRAM, 3 WRAM, 4 OAM, 5 IO
- i_mem_rdata  in  8  external read data
- o_ie  out  8  interrupt-enable register (FFFF), to the interrupt controller

Behaviour:
- Reset: asynchronous on i_reset high.
  - State goes to IDLE; o_cpu_ready=1; o_cpu_done, o_mem_re, o_mem_we = 0.
  - o_mem_addr, o_mem_wdata, o_cpu_rdata, o_mem_region = 0; o_ie = 8'h00.
  - HRAM contents are not reset.
- Decode (combinational on i_cpu_addr):
  - 0000–7FFF ROM; 8000–9FFF VRAM; A000–BFFF EXTRAM; C000–DFFF WRAM.
  - E000–FDFF echo (see Optional Feature); FE00–FE9F OAM; FEA0–FEFF unusable.
  - FF00–FF7F IO; FF80–FFFE HRAM; FFFF IE.
- Accept: a request is accepted when i_cpu_req && o_cpu_ready at a clock edge. The address, we, wdata and decoded region are latched. o_cpu_ready = (state==IDLE).
- FSM states: IDLE, EXT, DONE.
  - IDLE → EXT on accept of an external region; load wait counter with WAIT_CYCLES.
  - IDLE → DONE on accept of an HRAM, IE, unusable or unmapped address.
  - EXT: o_mem_re or o_mem_we held high with stable addr, wdata and region. Counter decrements each cycle.
  - EXT → DONE when counter==0 (EXT lasts WAIT_CYCLES+1 cycles). i_mem_rdata is captured into o_cpu_rdata on that final EXT edge.
  - DONE: o_cpu_done=1 for exactly one cycle, strobes low, then → IDLE.
- Latency from accept edge to the done cycle:
  - Internal/unmapped: 1 cycle.
  - External: WAIT_CYCLES+2 cycles.
  - The next request can be accepted in the cycle after done, so back-to-back internal accesses complete every 2 cycles.
- Internal accesses:
  - HRAM write is committed at the accept edge. HRAM read data is registered and presented in DONE.
  - IE write updates o_ie at the accept edge; IE read returns o_ie.
  - Unusable/unmapped reads return UNMAPPED_DATA; writes are dropped with no external strobe. o_cpu_done is still pulsed.
- i_cpu_req while busy is ignored; the CPU must hold the request until o_cpu_ready.
- o_cpu_rdata holds its last value until the next read completes; it is unchanged by writes.
- Reset mid-access: strobes drop immediately, no done pulse, and the pending access is abandoned.

Optional Feature:
- Macro: GB80_ECHO_RAM_EN.
- Defined: E000–FDFF is treated as WRAM. o_mem_region=3 and o_mem_addr = i_cpu_addr − 16'h2000, with normal external timing.
- Undefined: E000–FDFF is treated as unmapped. Reads return UNMAPPED_DATA with 1-cycle latency and writes are dropped.

Decomposition:
- Shared include gb80_mem_defs.vh holds:
  - region codes (ROM/VRAM/EXTRAM/WRAM/OAM/IO);
  - address boundary constants (8000, A000, C000, E000, FE00, FEA0, FF00, FF80, FFFF);
  - FSM state encodings.
- Sub-module gb80_hram: 127×8 array, synchronous write, registered read, 7-bit index = addr[6:0] with 7F unused.

Test Plan:
- WAIT_CYCLES=1, read 0x0150 with i_mem_rdata=8'h3E → o_mem_re high 2 cycles with region 0; o_cpu_done 3 cycles after accept; o_cpu_rdata=8'h3E.
- Write 8'hA5 to 0xFF90, then read 0xFF90 → no external strobes; each done 1 cycle after accept; read returns 8'hA5.
- Write 8'h1F to 0xFFFF → o_ie=8'h1F after the accept edge; read 0xFFFF returns 8'h1F.
- Read 0xFEA5 → no strobe; o_cpu_rdata=8'hFF. Write 0xFEA5 → done pulse only.
- With GB80_ECHO_RAM_EN, write 8'h77 to 0xE010 → o_mem_addr=16'hC010, o_mem_we=1, region 3. Without the macro → no strobe, done after 1 cycle.
- Assert i_reset during EXT of a 0x9800 read → o_mem_re falls asynchronously, no done pulse, o_cpu_ready=1 after release, o_ie=8'h00.
